ball_engine: RTL
================

// Module: ball_engine
// PURPOSE
//  Pong ball: consumes the left/right bar rectangles (x1,x2,y1,y2 edges) and moves the ball one step per animation strobe.
//  Bounces off the top/bottom walls and the bars, and detects misses. Keeps both scores and runs the serve/game sequence.
//  Sits between the two bar instances and the pixel renderer; its out_* edges feed the renderer just as the bar edges do.
// PARAMETERS
//  H_SIZE      8    half ball side (px)
//  IX          320  serve position x (ball centre)
//  IY          240  serve position y
//  SPEED       2    initial step per strobe, both axes (px)
//  MAX_SPEED   6    speed ceiling (used only with BALL_SPEEDUP_EN)
//  D_WIDTH     639  display width
//  D_HEIGHT    470  display height
//  SERVE_DELAY 60   strobes spent in SERVE before the ball moves
//  MAX_SCORE   9    score at which the game ends
// PORTS
//  in_clock      in   1   base clock
//  in_reset_n    in   1   synchronous, active-low reset
//  in_ani_stb    in   1   animation strobe, 1 clk pulse per frame
//  in_animate    in   1   motion enabled while high
//  in_serve      in   1   serve/restart button (level)
//  in_bl_x1..y2  in   4x12 left bar edges (x1,x2,y1,y2)
//  in_br_x1..y2  in   4x12 right bar edges
//  out_x1..y2    out  4x12 ball edges = centre -/+ H_SIZE
//  out_score_l   out  4   left player score
//  out_score_r   out  4   right player score
//  out_point     out  2   1-clk pulse: [0] left scored, [1] right scored
//  out_state     out  3   FSM state, for debug and the HUD
// BEHAVIOUR
//  - Reset (in_reset_n=0 at posedge): centre=(IX,IY), dx=+1 (right), dy=+1 (down), speed=SPEED.
//    Scores=0, out_point=0, state=IDLE, serve counter=0. Takes priority over all other events.
//  - All motion, collision and counter updates happen only on clocks where in_ani_stb=1 and in_animate=1.
//    in_serve and the score pulse are evaluated every clock.
//  - FSM:
//    IDLE: ball at (IX,IY). in_serve=1 -> SERVE.
//    SERVE: counter counts strobes. At count == SERVE_DELAY-1: clear counter -> PLAY.
//    PLAY: move/bounce, see below.
//    SCORED: lasts exactly 1 clk. Pulses out_point and increments the scorer's score.
//      Then centre=(IX,IY) and speed=SPEED; dx points toward the player who conceded.
//      Goes to OVER if the new score == MAX_SCORE, else to SERVE.
//    OVER: ball frozen at the centre. in_serve=1 -> clear both scores -> SERVE.
//  - PLAY, per strobe; nx,ny = candidate centre (current centre +/- speed):
//    wall: dy=-1 and y-H_SIZE <= speed -> dy=+1, y unchanged this frame.
//      dy=+1 and y+H_SIZE+speed >= D_HEIGHT -> dy=-1, y unchanged.
//    bar: the candidate ball rect overlaps a bar rect (inclusive edges) and dx points toward that bar
//      -> dx flips, x unchanged this frame. If dx points away, ignore the overlap (no double flip).
//    miss: dx=-1 and x-H_SIZE <= speed with no left-bar hit -> SCORED, right scores.
//      dx=+1 and x+H_SIZE+speed >= D_WIDTH with no right-bar hit -> SCORED, left scores.
//    Priority: bar hit over miss. Wall and bar on the same strobe: both axes flip.
//  - Arithmetic: 12-bit unsigned. The guards above are evaluated before any subtraction, so coordinates never underflow.
//  - Scores saturate at MAX_SCORE. in_animate=0 freezes the ball and the serve counter; the FSM state is held.
//  - The bar inputs are sampled combinationally on the strobe clock; no handshake.
// CONFIGURATION
//  BALL_SPEEDUP_EN defined: each bar hit sets speed=min(speed+1,MAX_SPEED). SCORED restores SPEED.
//  BALL_SPEEDUP_EN undefined: speed is constant SPEED and MAX_SPEED is unused.
// STRUCTURE
//  pong_pkg holds the state encodings (IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4) and the display constants shared with bar.
//  Sub-module rect_overlap: combinational inclusive test of two rectangles, instanced twice (left and right bar).
// TESTING
//  1. reset_n=0 then 1 -> out_x1=312, out_x2=328, out_y1=232, out_y2=248, scores=0, state=IDLE.
//  2. serve, then 60 strobes -> state=PLAY. Next strobe: centre=(322,242).
//  3. Ball at y=10 with dy=-1 and speed=2 -> dy=+1, y stays 10. Next strobe y=12.
//  4. Left bar x1..x2=0..20, y=150..330; ball x=30, y=240, dx=-1 -> dx=+1.
//     With BALL_SPEEDUP_EN, speed becomes 3.
//  5. Left bar moved off the ball path; ball reaches x=10 -> out_point=2'b10 for 1 clk, score_r=1,
//     centre=(320,240), dx=-1, state=SERVE.
//  6. score_l=8, then the left player scores -> score_l=9, state=OVER.
//     reset_n=0 mid-PLAY -> IDLE, scores=0 on the next clock.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong types: FSM state encodings, display limits and coordinate rect type.
// Latency: none (types, constants and one pure function only).
// Backpressure: not applicable.
package pong_pkg;

  localparam int COORD_W = 12;
  localparam int DISP_W  = 639;
  localparam int DISP_H  = 470;

  typedef logic [COORD_W-1:0] coord_t;

  // Edges of an axis-aligned rectangle, inclusive on all four sides.
  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
  } rect_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Score increment that sticks at the ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Inclusive overlap test of two rectangles (touching edges count as overlap).
// Latency: combinational.
// Backpressure: none.
module rect_overlap
  import pong_pkg::*;
(
  input  rect_t a_i,
  input  rect_t b_i,
  output logic  hit_o
);

  assign hit_o = (a_i.x1 <= b_i.x2) && (b_i.x1 <= a_i.x2) &&
                 (a_i.y1 <= b_i.y2) && (b_i.y1 <= a_i.y2);

endmodule

// File: rtl/ball_engine.sv
// Pong ball: moves one step per animation strobe, bounces off walls/bars, keeps score, runs serve/game FSM.
// Latency: one clock from strobe to new edges; a miss shows score/point one clock later (SCORED state).
// Backpressure: none; bar edges are sampled on the strobe clock. BALL_SPEEDUP_EN enables speed-up on bar hits.
module ball_engine
  import pong_pkg::*;
#(
  parameter int H_SIZE      = 8,
  parameter int IX          = 320,
  parameter int IY          = 240,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 6,
  parameter int D_WIDTH     = DISP_W,
  parameter int D_HEIGHT    = DISP_H,
  parameter int SERVE_DELAY = 60,
  parameter int MAX_SCORE   = 9
) (
  input  logic         in_clock,
  input  logic         in_reset_n,
  input  logic         in_ani_stb,
  input  logic         in_animate,
  input  logic         in_serve,
  input  logic [11:0]  in_bl_x1,
  input  logic [11:0]  in_bl_x2,
  input  logic [11:0]  in_bl_y1,
  input  logic [11:0]  in_bl_y2,
  input  logic [11:0]  in_br_x1,
  input  logic [11:0]  in_br_x2,
  input  logic [11:0]  in_br_y1,
  input  logic [11:0]  in_br_y2,
  output logic [11:0]  out_x1,
  output logic [11:0]  out_x2,
  output logic [11:0]  out_y1,
  output logic [11:0]  out_y2,
  output logic [3:0]   out_score_l,
  output logic [3:0]   out_score_r,
  output logic [1:0]   out_point,
  output logic [2:0]   out_state
);

  // Speed register is sized for the larger of the start speed and the ceiling.
  localparam int SPD_TOP = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
  localparam int SPD_W   = $clog2(SPD_TOP + 1);
  localparam int CNT_W   = $clog2(SERVE_DELAY + 1);

  localparam coord_t           HS         = coord_t'(H_SIZE);
  localparam coord_t           CX         = coord_t'(IX);
  localparam coord_t           CY         = coord_t'(IY);
  localparam coord_t           DW         = coord_t'(D_WIDTH);
  localparam coord_t           DH         = coord_t'(D_HEIGHT);
  localparam logic [SPD_W-1:0] SPD_INIT   = SPD_W'(SPEED);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0]       MAX_SC     = 4'(MAX_SCORE);
`ifdef BALL_SPEEDUP_EN
  localparam logic [SPD_W-1:0] SPD_CEIL   = SPD_W'(MAX_SPEED);
`endif

  state_e           state_q;
  coord_t           x_q, y_q;
  logic             dx_neg_q, dy_neg_q;
  logic [SPD_W-1:0] speed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       score_l_q, score_r_q;
  logic [1:0]       point_q;
  logic             right_scored_q;

  coord_t     spd, nx_d, ny_d;
  rect_t      cand, bar_l, bar_r;
  logic       ovl_l, ovl_r, hit_l, hit_r, bar_hit;
  logic       wall, miss_l, miss_r, step;
  logic [3:0] score_l_d, score_r_d;

  assign step = in_ani_stb && in_animate;
  assign spd  = coord_t'(speed_q);

  // Guards compare against speed+H_SIZE so no subtraction can underflow.
  assign wall = ( dy_neg_q && (y_q <= spd + HS)) ||
                (!dy_neg_q && (y_q + HS + spd >= DH));

  // Candidate centre, saturating at zero on the left/top side.
  assign nx_d = dx_neg_q ? ((x_q > spd) ? x_q - spd : coord_t'(0)) : x_q + spd;
  assign ny_d = dy_neg_q ? ((y_q > spd) ? y_q - spd : coord_t'(0)) : y_q + spd;

  assign cand = '{x1: (nx_d > HS) ? nx_d - HS : coord_t'(0), x2: nx_d + HS,
                  y1: (ny_d > HS) ? ny_d - HS : coord_t'(0), y2: ny_d + HS};
  assign bar_l = '{x1: in_bl_x1, x2: in_bl_x2, y1: in_bl_y1, y2: in_bl_y2};
  assign bar_r = '{x1: in_br_x1, x2: in_br_x2, y1: in_br_y1, y2: in_br_y2};

  rect_overlap u_ovl_l (.a_i(cand), .b_i(bar_l), .hit_o(ovl_l));
  rect_overlap u_ovl_r (.a_i(cand), .b_i(bar_r), .hit_o(ovl_r));

  // An overlap only counts while heading toward that bar, so a ball leaving a bar never re-flips.
  assign hit_l   = ovl_l &&  dx_neg_q;
  assign hit_r   = ovl_r && !dx_neg_q;
  assign bar_hit = hit_l || hit_r;
  assign miss_l  =  dx_neg_q && (x_q <= spd + HS)       && !hit_l;
  assign miss_r  = !dx_neg_q && (x_q + HS + spd >= DW)  && !hit_r;

  assign score_l_d = sat_inc(score_l_q, MAX_SC);
  assign score_r_d = sat_inc(score_r_q, MAX_SC);

  // Game FSM with ball position, direction, speed, scores and point pulse.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state_q        <= ST_IDLE;
      x_q            <= CX;
      y_q            <= CY;
      dx_neg_q       <= 1'b0;
      dy_neg_q       <= 1'b0;
      speed_q        <= SPD_INIT;
      cnt_q          <= '0;
      score_l_q      <= '0;
      score_r_q      <= '0;
      point_q        <= '0;
      right_scored_q <= 1'b0;
    end else begin
      point_q <= '0;
      case (state_q)
        ST_IDLE: begin
          x_q <= CX;
          y_q <= CY;
          if (in_serve) begin
            cnt_q   <= '0;
            state_q <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (step) begin
            if (cnt_q == SERVE_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_PLAY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (step) begin
            if (wall) dy_neg_q <= !dy_neg_q;
            else      y_q      <= ny_d;
            if (bar_hit) begin
              dx_neg_q <= !dx_neg_q;
`ifdef BALL_SPEEDUP_EN
              if (speed_q < SPD_CEIL) speed_q <= speed_q + SPD_W'(1);
`endif
            end else if (miss_l || miss_r) begin
              right_scored_q <= miss_l;
              state_q        <= ST_SCORED;
            end else begin
              x_q <= nx_d;
            end
          end
        end
        ST_SCORED: begin
          x_q     <= CX;
          y_q     <= CY;
          speed_q <= SPD_INIT;
          // Next serve heads toward the player who just conceded.
          if (right_scored_q) begin
            point_q   <= 2'b10;
            score_r_q <= score_r_d;
            dx_neg_q  <= 1'b1;
            state_q   <= (score_r_d == MAX_SC) ? ST_OVER : ST_SERVE;
          end else begin
            point_q   <= 2'b01;
            score_l_q <= score_l_d;
            dx_neg_q  <= 1'b0;
            state_q   <= (score_l_d == MAX_SC) ? ST_OVER : ST_SERVE;
          end
        end
        ST_OVER: begin
          x_q <= CX;
          y_q <= CY;
          if (in_serve) begin
            score_l_q <= '0;
            score_r_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_SERVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_x1      = x_q - HS;
  assign out_x2      = x_q + HS;
  assign out_y1      = y_q - HS;
  assign out_y2      = y_q + HS;
  assign out_score_l = score_l_q;
  assign out_score_r = score_r_q;
  assign out_point   = point_q;
  assign out_state   = state_q;

endmodule
